bitblock_4_collect: RTL and testbench

Downstream result collector for the 4-bit bit-serial MAC core. It accepts one 4-bit `out` nibble per beat, LSB nibble first. After the last nibble it captures the core's registered carry-out one cycle later and assembles a `4*NIBBLES+1`-bit result. The result is buffered in a 2-entry FIFO behind a valid/ready handshake, so the core can start the next accumulation while the consumer stalls.

---
 rtl/bitblock_4_collect_if.sv | 28 ++
 rtl/bitblock_4_collect.sv | 116 +++++++++++
 tb/tb_bitblock_4_collect.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bitblock_4_collect_if.sv
// Handshake bundle between the bit-serial MAC core, the result collector and the consumer.
// master drives beats/flush/consumer-ready; slave is the collector.
interface bitblock_4_collect_if #(
   parameter int NIBBLES = 4
) ();
   localparam int RW = 4*NIBBLES+1;

   logic          clr;
   logic          in_valid;
   logic          in_last;
   logic [3:0]    out_nib;
   logic          co;
   logic          in_ready;
   logic          res_valid;
   logic          res_ready;
   logic [RW-1:0] res_data;
   logic          err;

   modport master (
      output clr, in_valid, in_last, out_nib, co, res_ready,
      input  in_ready, res_valid, res_data, err
   );

   modport slave (
      input  clr, in_valid, in_last, out_nib, co, res_ready,
      output in_ready, res_valid, res_data, err
   );
endinterface

// File: rtl/bitblock_4_collect.sv
// Collects NIBBLES bit-serial nibbles plus the trailing carry into one result,
// buffered in a 2-entry FIFO so the core can keep accumulating while the consumer stalls.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// COLL  | frame in progress, beat_q nibbles already stored
// CARRY | one cycle: sample co, push result, restart
module bitblock_4_collect #(
   parameter int NIBBLES = 4
) (
   input  logic              clk,
   input  logic              rstn,
   bitblock_4_collect_if.slave bus
);
   localparam int         RW        = 4*NIBBLES+1;
   localparam logic [4:0] LAST_BEAT = 5'(NIBBLES-1);

   typedef enum logic [1:0] {IDLE, COLL, CARRY} state_t;

   state_t        state_q;
   logic [RW-2:0] acc_q;
   logic [4:0]    beat_q;
   logic          err_q;

   logic [RW-1:0] mem_q [2];
   logic          rd_q;
   logic          wr_q;
   logic [1:0]    cnt_q;
   logic [1:0]    cnt_d;

   logic          ready;
   logic          accept;
   logic          closing;
   logic          push;
   logic          pop;
   logic [RW-2:0] nib_pos;

   always_comb begin
      ready   = (state_q != CARRY) && (cnt_q != 2'd2) && !bus.clr;
      accept  = bus.in_valid && ready;
      closing = bus.in_last || (beat_q == LAST_BEAT);
      push    = (state_q == CARRY);
      pop     = (cnt_q != 2'd0) && bus.res_ready;
      nib_pos = {{(RW-5){1'b0}}, bus.out_nib} << {beat_q, 2'b00};
      cnt_d   = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 2'd1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 2'd1;
      end
   end

   // acc_q is zero at frame start, so OR-ing each nibble into place is a plain write
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         acc_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else if (bus.clr) begin
         state_q <= IDLE;
         acc_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, COLL: begin
               if (accept) begin
                  acc_q   <= acc_q | nib_pos;
                  beat_q  <= beat_q + 5'd1;
                  state_q <= closing ? CARRY : COLL;
                  // short frame: last too early; long frame: final slot without last
                  if (bus.in_last != (beat_q == LAST_BEAT)) begin
                     err_q <= 1'b1;
                  end
               end
            end
            CARRY: begin
               acc_q   <= '0;
               beat_q  <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // in_ready gating guarantees the FIFO has room whenever CARRY pushes
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else if (bus.clr) begin
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= {bus.co, acc_q};
            wr_q        <= ~wr_q;
         end
         if (pop) begin
            rd_q <= ~rd_q;
         end
         cnt_q <= cnt_d;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.res_valid = (cnt_q != 2'd0);
   assign bus.res_data  = mem_q[rd_q];
   assign bus.err       = err_q;
endmodule

// File: tb/tb_bitblock_4_collect.sv
// Bench for bitblock_4_collect: fixed vector table, directed corner sequences and a
// random run, all checked against a frame-level queue model.
module tb_bitblock_4_collect;
   localparam int N  = 4;
   localparam int RW = 4*N+1;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   bitblock_4_collect_if #(.NIBBLES(N)) bus ();
   bitblock_4_collect #(.NIBBLES(N)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   int total = 0;
   int bad   = 0;

   logic [3:0]    m_nibs [$];
   logic [RW-1:0] m_fifo [$];
   bit            m_carry;
   bit            m_err;

   typedef struct {
      bit            v, l;
      logic [3:0]    nib;
      bit            co, rr, clr;
      bit            e_rdy, e_rv;
      logic [RW-1:0] e_data;
      bit            e_err;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_nibs.delete();
      m_fifo.delete();
      m_carry = 0;
      m_err   = 0;
   endtask

   function automatic bit m_ready();
      return !m_carry && (m_fifo.size() < 2) && !bus.clr;
   endfunction

   // frame-level view: a frame is a list of nibbles, closed by in_last or by filling N slots
   task automatic model_edge();
      bit            rdy;
      logic [RW-1:0] res;
      rdy = m_ready();
      if (bus.clr) begin
         model_reset();
      end else begin
         if (m_fifo.size() != 0 && bus.res_ready) void'(m_fifo.pop_front());
         if (m_carry) begin
            res = '0;
            foreach (m_nibs[i]) res = res | (RW'(m_nibs[i]) << (4*i));
            res[RW-1] = bus.co;
            m_fifo.push_back(res);
            m_nibs.delete();
            m_carry = 0;
         end else if (bus.in_valid && rdy) begin
            m_nibs.push_back(bus.out_nib);
            if (bus.in_last || m_nibs.size() == N) begin
               m_carry = 1;
               if (!bus.in_last || m_nibs.size() != N) m_err = 1;
            end
         end
      end
   endtask

   task automatic cyc(input bit v, input bit l, input logic [3:0] nib, input bit co,
                      input bit rr, input bit clr, output bit rdy_seen);
      bus.in_valid  = v;
      bus.in_last   = l;
      bus.out_nib   = nib;
      bus.co        = co;
      bus.res_ready = rr;
      bus.clr       = clr;
      #1;
      rdy_seen = bus.in_ready;
      chk("in_ready", bus.in_ready, m_ready());
      model_edge();
      @(posedge clk);
      #1;
      chk("res_valid", bus.res_valid, m_fifo.size() != 0);
      if (m_fifo.size() != 0) chk("res_data", bus.res_data, m_fifo[0]);
      chk("err", bus.err, m_err);
   endtask

   bit rdy;

   initial begin
      bus.in_valid = 0; bus.in_last = 0; bus.out_nib = 0;
      bus.co = 0; bus.res_ready = 0; bus.clr = 0;
      model_reset();
      #12;
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_err", bus.err, 0);
      rstn = 1'b1;

      // nominal frame, then a short frame held under backpressure, then clr
      tbl[0]  = '{1, 0, 4'h5, 0, 1, 0, 1, 0, '0, 0};
      tbl[1]  = '{1, 0, 4'hA, 0, 1, 0, 1, 0, '0, 0};
      tbl[2]  = '{1, 0, 4'h3, 0, 1, 0, 1, 0, '0, 0};
      tbl[3]  = '{1, 1, 4'hC, 0, 1, 0, 1, 0, '0, 0};
      tbl[4]  = '{0, 0, 4'h0, 1, 1, 0, 0, 1, 17'h1C3A5, 0};
      tbl[5]  = '{1, 0, 4'h7, 0, 1, 0, 1, 0, '0, 0};
      tbl[6]  = '{1, 1, 4'h1, 0, 1, 0, 1, 0, '0, 1};
      tbl[7]  = '{0, 0, 4'h0, 0, 1, 0, 0, 1, 17'h00017, 1};
      tbl[8]  = '{0, 0, 4'h0, 0, 0, 0, 1, 1, 17'h00017, 1};
      tbl[9]  = '{0, 0, 4'h0, 0, 1, 0, 1, 0, '0, 1};
      tbl[10] = '{0, 0, 4'h0, 0, 1, 1, 0, 0, '0, 0};
      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].v, tbl[i].l, tbl[i].nib, tbl[i].co, tbl[i].rr, tbl[i].clr, rdy);
         chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_rv", i), bus.res_valid, tbl[i].e_rv);
         if (tbl[i].e_rv) chk($sformatf("tbl%0d_data", i), bus.res_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_err", i), bus.err, tbl[i].e_err);
      end

      // long frame: 4th beat without last closes the frame, 5th beat starts a new one
      for (int i = 1; i <= 4; i++) cyc(1, 0, 4'(i), 0, 1, 0, rdy);
      chk("long_err", bus.err, 1);
      cyc(1, 0, 4'h5, 1, 1, 0, rdy);
      chk("long_carry_stall", rdy, 0);
      chk("long_res", bus.res_data, 17'h14321);
      cyc(1, 0, 4'h5, 0, 1, 0, rdy);
      chk("long_next_acc", rdy, 1);
      cyc(1, 0, 4'h6, 0, 1, 0, rdy);
      cyc(1, 0, 4'h7, 0, 1, 0, rdy);
      cyc(1, 1, 4'h8, 0, 1, 0, rdy);
      cyc(0, 0, 4'h0, 0, 1, 0, rdy);
      chk("long_next_res", bus.res_data, 17'h08765);
      cyc(0, 0, 4'h0, 0, 1, 1, rdy);

      // stall: two frames fill the FIFO, third frame waits
      for (int i = 1; i <= 4; i++) cyc(1, i == 4, 4'(i), 0, 0, 0, rdy);
      cyc(0, 0, 4'h0, 0, 0, 0, rdy);
      for (int i = 5; i <= 8; i++) cyc(1, i == 8, 4'(i), 0, 0, 0, rdy);
      cyc(0, 0, 4'h0, 1, 0, 0, rdy);
      chk("stall_head_a", bus.res_data, 17'h04321);
      cyc(1, 0, 4'h9, 0, 0, 0, rdy);
      chk("stall_full", rdy, 0);
      cyc(1, 0, 4'h9, 0, 1, 0, rdy);
      chk("stall_full2", rdy, 0);
      chk("stall_head_b", bus.res_data, 17'h18765);
      cyc(1, 0, 4'h9, 0, 1, 0, rdy);
      cyc(1, 0, 4'hA, 0, 1, 0, rdy);
      cyc(1, 0, 4'hB, 0, 1, 0, rdy);
      cyc(1, 1, 4'hC, 0, 1, 0, rdy);
      cyc(0, 0, 4'h0, 0, 1, 0, rdy);
      chk("stall_c", bus.res_data, 17'h0CBA9);
      cyc(0, 0, 4'h0, 0, 1, 1, rdy);

      // clr mid-frame with one buffered (short, erroring) result
      cyc(1, 0, 4'h7, 0, 0, 0, rdy);
      cyc(1, 1, 4'h1, 0, 0, 0, rdy);
      cyc(0, 0, 4'h0, 1, 0, 0, rdy);
      chk("clr_pre_err", bus.err, 1);
      cyc(1, 0, 4'hE, 0, 0, 0, rdy);
      cyc(1, 0, 4'hF, 0, 0, 0, rdy);
      cyc(0, 0, 4'h0, 0, 0, 1, rdy);
      chk("clr_rv", bus.res_valid, 0);
      chk("clr_err", bus.err, 0);
      for (int i = 1; i <= 4; i++) cyc(1, i == 4, 4'(2*i), 0, 1, 0, rdy);
      cyc(0, 0, 4'h0, 0, 1, 0, rdy);
      chk("clr_clean", bus.res_data, 17'h08642);
      chk("clr_clean_err", bus.err, 0);

      // async reset while in CARRY: nothing is pushed
      for (int i = 1; i <= 4; i++) cyc(1, i == 4, 4'(i), 0, 1, 0, rdy);
      bus.in_valid = 0; bus.in_last = 0; bus.co = 1;
      #1 rstn = 1'b0;
      #2 chk("arst_rv_low", bus.res_valid, 0);
      rstn = 1'b1;
      model_reset();
      #1 chk("arst_ready", bus.in_ready, 1);
      @(posedge clk);
      #1 chk("arst_no_push", bus.res_valid, 0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, rdy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
